render_scheduler: RTL and testbench

Frame-level sequencer for the renderer pipeline. After reset it triggers the one-time model load. Then, once per VGA vertical sync, it runs clear → project+draw. It owns the single write port of the ping-pong frame buffer, muxing clear and draw pixel writes onto it. It also signals frame completion for the buffer swap and counts rendered and overrun frames for debug display.

---
 rtl/renderer_pkg.sv | 17 +
 rtl/rise_detect.sv | 20 ++
 rtl/render_scheduler.sv | 155 +++++++++++++++
 tb/tb_render_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/renderer_pkg.sv
// Shared types and constants for the renderer pipeline (scheduler, clear, draw, frame buffer).
package renderer_pkg;

  localparam int unsigned XY_W     = 10;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef enum logic [2:0] {
    S_LOAD_START = 3'd0,
    S_LOAD       = 3'd1,
    S_WAIT_VS    = 3'd2,
    S_CLEAR      = 3'd3,
    S_RENDER     = 3'd4,
    S_DONE       = 3'd5
  } sched_state_t;

endpackage

// File: rtl/rise_detect.sv
// One-flop rising-edge detector; the reset value decides whether a level high at reset reads as an edge.
module rise_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) d_q <= RST_VAL;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/render_scheduler.sv
// Frame-level sequencer: model load, then clear -> project+draw once per vertical sync,
// owning the frame-buffer write port and the frame/overrun debug counters.
module render_scheduler #(
  parameter int unsigned XY_W  = renderer_pkg::XY_W,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned OVR_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  input  logic             pause,
  input  logic             load_done,
  input  logic             clear_done,
  input  logic             proj_done,
  input  logic             draw_done,
  input  logic             fifo_empty,
  input  logic             clear_we,
  input  logic [XY_W-1:0]  clear_x,
  input  logic [XY_W-1:0]  clear_y,
  input  logic             draw_we,
  input  logic [XY_W-1:0]  draw_x,
  input  logic [XY_W-1:0]  draw_y,
  output logic             load_obj,
  output logic             clear_start,
  output logic             proj_start,
  output logic             draw_start,
  output logic             fb_we,
  output logic [XY_W-1:0]  fb_x,
  output logic [XY_W-1:0]  fb_y,
  output logic             fb_data,
  output logic             frame_clk_rising_edge,
  output logic             frame_done,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count,
  output logic [OVR_W-1:0] overrun_count
);

  import renderer_pkg::*;

  sched_state_t state_q, state_d;
  logic p_seen_q, p_seen_d, d_seen_q, d_seen_d;
  logic load_obj_d, clear_start_d, render_start_d, render_start_q;
  logic vs_in_frame;

  // Reset value 1 so a VS level already high at reset is not taken as an edge
  rise_detect #(.RST_VAL(1'b1)) u_vs_rise (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (frame_clk),
    .rise  (frame_clk_rising_edge)
  );

  assign vs_in_frame = (state_q == S_CLEAR) || (state_q == S_RENDER) || (state_q == S_DONE);

  always_comb begin
    state_d        = state_q;
    p_seen_d       = p_seen_q;
    d_seen_d       = d_seen_q;
    load_obj_d     = 1'b0;
    clear_start_d  = 1'b0;
    render_start_d = 1'b0;
    case (state_q)
      S_LOAD_START: begin
        load_obj_d = 1'b1;
        state_d    = S_LOAD;
      end
      S_LOAD: if (load_done) state_d = S_WAIT_VS;
      S_WAIT_VS: begin
        if (frame_clk_rising_edge && !pause) begin
          clear_start_d = 1'b1;
          state_d       = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (clear_done) begin
          render_start_d = 1'b1;
          p_seen_d       = 1'b0;
          d_seen_d       = 1'b0;
          state_d        = S_RENDER;
        end
      end
      S_RENDER: begin
        // Draw idle only counts once projection has finished feeding the FIFO
        p_seen_d = p_seen_q | proj_done;
        if (draw_done && fifo_empty && p_seen_d) d_seen_d = 1'b1;
        if (p_seen_d && d_seen_d) state_d = S_DONE;
      end
      S_DONE:  state_d = S_WAIT_VS;
      default: state_d = S_LOAD_START;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= S_LOAD_START;
      p_seen_q       <= 1'b0;
      d_seen_q       <= 1'b0;
      load_obj       <= 1'b0;
      clear_start    <= 1'b0;
      render_start_q <= 1'b0;
      busy           <= 1'b1;
    end else begin
      state_q        <= state_d;
      p_seen_q       <= p_seen_d;
      d_seen_q       <= d_seen_d;
      load_obj       <= load_obj_d;
      clear_start    <= clear_start_d;
      render_start_q <= render_start_d;
      busy           <= (state_d == S_LOAD_START) || (state_d == S_LOAD) ||
                        (state_d == S_CLEAR) || (state_d == S_RENDER);
    end
  end

  assign proj_start = render_start_q;
  assign draw_start = render_start_q;

  // Frame completion flag and debug counters; an edge landing in DONE is an overrun, not a swap
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_done    <= 1'b0;
      frame_count   <= '0;
      overrun_count <= '0;
    end else begin
      if (state_q == S_DONE) begin
        frame_done  <= 1'b1;
        frame_count <= frame_count + CNT_W'(1);
      end else if (frame_clk_rising_edge && !pause) begin
        frame_done  <= 1'b0;
      end
      if (frame_clk_rising_edge && vs_in_frame && (overrun_count != {OVR_W{1'b1}}))
        overrun_count <= overrun_count + OVR_W'(1);
    end
  end

  // Single frame-buffer write port: clear writes background, draw writes foreground
  always_comb begin
    fb_we   = 1'b0;
    fb_data = 1'b0;
    fb_x    = draw_x;
    fb_y    = draw_y;
    case (state_q)
      S_CLEAR: begin
        fb_we = clear_we;
        fb_x  = clear_x;
        fb_y  = clear_y;
      end
      S_RENDER: begin
        fb_we   = draw_we;
        fb_data = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_render_scheduler.sv
// Directed bench for render_scheduler with a cycle-level reference model and literal spot checks.
module tb_render_scheduler;

  localparam int unsigned XW = 10;
  localparam int unsigned CW = 16;
  localparam int unsigned OW = 8;

  localparam int P_LS = 0, P_LD = 1, P_WV = 2, P_CL = 3, P_RN = 4, P_DN = 5;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic frame_clk = 1'b0, pause = 1'b0, load_done = 1'b0, clear_done = 1'b0;
  logic proj_done = 1'b0, draw_done = 1'b0, fifo_empty = 1'b1;
  logic clear_we = 1'b0, draw_we = 1'b0;
  logic [XW-1:0] clear_x = '0, clear_y = '0, draw_x = '0, draw_y = '0;
  logic load_obj, clear_start, proj_start, draw_start, fb_we, fb_data;
  logic [XW-1:0] fb_x, fb_y;
  logic frame_clk_rising_edge, frame_done, busy;
  logic [CW-1:0] frame_count;
  logic [OW-1:0] overrun_count;

  always #10 Clk = ~Clk;

  render_scheduler #(.XY_W(XW), .CNT_W(CW), .OVR_W(OW)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .pause(pause),
    .load_done(load_done), .clear_done(clear_done), .proj_done(proj_done),
    .draw_done(draw_done), .fifo_empty(fifo_empty),
    .clear_we(clear_we), .clear_x(clear_x), .clear_y(clear_y),
    .draw_we(draw_we), .draw_x(draw_x), .draw_y(draw_y),
    .load_obj(load_obj), .clear_start(clear_start), .proj_start(proj_start),
    .draw_start(draw_start), .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y),
    .fb_data(fb_data), .frame_clk_rising_edge(frame_clk_rising_edge),
    .frame_done(frame_done), .busy(busy), .frame_count(frame_count),
    .overrun_count(overrun_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: spec-level phase, sticky flags and counters
  int m_phase, m_fc, m_ov;
  bit m_vs_prev, m_load, m_cs, m_rs, m_fd, m_ps, m_ds, m_edge;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_phase = P_LS; m_vs_prev = 1'b1;
      m_load = 0; m_cs = 0; m_rs = 0; m_fd = 0; m_ps = 0; m_ds = 0;
      m_fc = 0; m_ov = 0;
    end else begin
      m_edge = frame_clk && !m_vs_prev;
      m_vs_prev = frame_clk;
      m_load = 0; m_cs = 0; m_rs = 0;
      if (m_edge && (m_phase == P_CL || m_phase == P_RN || m_phase == P_DN))
        m_ov = (m_ov >= 255) ? 255 : m_ov + 1;
      if (m_phase == P_DN) begin
        m_fd = 1; m_fc = (m_fc + 1) % 65536;
      end else if (m_edge && !pause) m_fd = 0;
      case (m_phase)
        P_LS: begin m_load = 1; m_phase = P_LD; end
        P_LD: if (load_done) m_phase = P_WV;
        P_WV: if (m_edge && !pause) begin m_cs = 1; m_phase = P_CL; end
        P_CL: if (clear_done) begin m_rs = 1; m_ps = 0; m_ds = 0; m_phase = P_RN; end
        P_RN: begin
          if (proj_done) m_ps = 1;
          if (m_ps && draw_done && fifo_empty) m_ds = 1;
          if (m_ps && m_ds) m_phase = P_DN;
        end
        default: m_phase = P_WV;
      endcase
    end
  end

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge Clk) begin
    int exp_we, exp_x, exp_y, exp_data;
    exp_we = 0; exp_data = 0; exp_x = int'(draw_x); exp_y = int'(draw_y);
    if (m_phase == P_CL) begin exp_we = int'(clear_we); exp_x = int'(clear_x); exp_y = int'(clear_y); end
    if (m_phase == P_RN) begin exp_we = int'(draw_we); exp_data = 1; end
    check("load_obj", int'(load_obj), int'(m_load));
    check("clear_start", int'(clear_start), int'(m_cs));
    check("proj_start", int'(proj_start), int'(m_rs));
    check("draw_start", int'(draw_start), int'(m_rs));
    check("vs_edge", int'(frame_clk_rising_edge), int'(frame_clk && !m_vs_prev));
    check("frame_done", int'(frame_done), int'(m_fd));
    check("busy", int'(busy), int'(m_phase == P_LS || m_phase == P_LD || m_phase == P_CL || m_phase == P_RN));
    check("frame_count", int'(frame_count), m_fc);
    check("overrun_count", int'(overrun_count), m_ov);
    check("fb_we", int'(fb_we), exp_we);
    check("fb_data", int'(fb_data), exp_data);
    check("fb_x", int'(fb_x), exp_x);
    check("fb_y", int'(fb_y), exp_y);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  initial begin
    step(3);
    Reset = 1'b0;                                   // cycle 0
    @(negedge Clk);
    check("lit_rst_load_obj", int'(load_obj), 0);
    check("lit_rst_busy", int'(busy), 1);
    check("lit_rst_count", int'(frame_count), 0);
    step(1);                                        // cycle 1
    @(negedge Clk);
    check("lit_load_obj_c1", int'(load_obj), 1);
    step(4);                                        // cycle 5
    load_done = 1'b1;
    step(1);                                        // cycle 6: WAIT_VS
    load_done = 1'b0;
    draw_we = 1'b1; draw_x = 10'd17; draw_y = 10'd23;
    @(negedge Clk);
    check("lit_wait_busy", int'(busy), 0);
    check("lit_wait_fb_we", int'(fb_we), 0);
    check("lit_wait_fb_x", int'(fb_x), 17);
    step(1);
    draw_we = 1'b0;
    step(2);

    // Frame 1: rise at n, clear_done n+20, proj_done n+50, draw_done n+60
    frame_clk = 1'b1;                               // n
    @(negedge Clk);
    check("lit_vs_edge", int'(frame_clk_rising_edge), 1);
    step(1);                                        // n+1
    clear_we = 1'b1; clear_x = 10'd639; clear_y = 10'd479;
    @(negedge Clk);
    check("lit_clear_start", int'(clear_start), 1);
    check("lit_clear_fb_we", int'(fb_we), 1);
    check("lit_clear_fb_data", int'(fb_data), 0);
    check("lit_clear_fb_x", int'(fb_x), 639);
    check("lit_clear_fb_y", int'(fb_y), 479);
    step(1); clear_we = 1'b0;                       // n+2
    step(3); frame_clk = 1'b0;                      // n+5
    step(15); clear_done = 1'b1;                    // n+20
    step(1); clear_done = 1'b0;                     // n+21
    @(negedge Clk);
    check("lit_proj_start", int'(proj_start), 1);
    check("lit_draw_start", int'(draw_start), 1);
    step(4); frame_clk = 1'b1;                      // n+25
    step(2); frame_clk = 1'b0;
    step(5); frame_clk = 1'b1;                      // n+32
    step(2); frame_clk = 1'b0;
    step(16); proj_done = 1'b1;                     // n+50
    step(1); proj_done = 1'b0;
    step(9); draw_done = 1'b1;                      // n+60
    step(1); draw_done = 1'b0;                      // n+61: DONE
    @(negedge Clk);
    check("lit_fd_not_yet", int'(frame_done), 0);
    step(1);                                        // n+62
    @(negedge Clk);
    check("lit_frame_done", int'(frame_done), 1);
    check("lit_frame_count1", int'(frame_count), 1);
    check("lit_overrun2", int'(overrun_count), 2);

    // Frame 2: early draw_done ignored, FIFO-not-empty ignored, edge in DONE
    step(3); frame_clk = 1'b1;
    step(3); frame_clk = 1'b0;
    step(3); clear_done = 1'b1;
    step(1); clear_done = 1'b0;
    step(2); draw_done = 1'b1;
    step(1); draw_done = 1'b0;
    step(3);
    @(negedge Clk);
    check("lit_early_draw_ignored", int'(busy), 1);
    proj_done = 1'b1;
    step(1); proj_done = 1'b0; fifo_empty = 1'b0; draw_done = 1'b1;
    step(1); draw_done = 1'b0; fifo_empty = 1'b1;
    step(2);
    @(negedge Clk);
    check("lit_fifo_busy", int'(busy), 1);
    draw_done = 1'b1;                               // k
    step(1); draw_done = 1'b0; frame_clk = 1'b1;    // k+1: DONE with edge
    step(1);
    @(negedge Clk);
    check("lit_done_edge_fd", int'(frame_done), 1);
    check("lit_done_edge_ovr", int'(overrun_count), 3);
    check("lit_frame_count2", int'(frame_count), 2);

    // Pause: three rises ignored
    step(2); frame_clk = 1'b0; pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(2); frame_clk = 1'b1;
      step(2); frame_clk = 1'b0;
    end
    step(1);
    @(negedge Clk);
    check("lit_pause_fd", int'(frame_done), 1);
    check("lit_pause_ovr", int'(overrun_count), 3);
    check("lit_pause_busy", int'(busy), 0);
    pause = 1'b0;

    // Frame 3: 300 rises while busy saturate the overrun counter
    step(2); frame_clk = 1'b1;
    step(1); frame_clk = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1); frame_clk = 1'b1;
      step(1); frame_clk = 1'b0;
    end
    @(negedge Clk);
    check("lit_ovr_sat", int'(overrun_count), 255);
    clear_done = 1'b1;
    step(1); clear_done = 1'b0; proj_done = 1'b1; draw_done = 1'b1;
    step(1); proj_done = 1'b0; draw_done = 1'b0;
    step(1);
    @(negedge Clk);
    check("lit_frame_count3", int'(frame_count), 3);

    // Reset mid-frame then a fresh load sequence
    step(2); frame_clk = 1'b1;
    step(1); frame_clk = 1'b0;
    step(3); Reset = 1'b1;
    @(negedge Clk);
    check("lit_midrst_busy", int'(busy), 1);
    check("lit_midrst_ovr", int'(overrun_count), 0);
    check("lit_midrst_count", int'(frame_count), 0);
    check("lit_midrst_fd", int'(frame_done), 0);
    step(2); Reset = 1'b0;
    step(1);
    @(negedge Clk);
    check("lit_reload_obj", int'(load_obj), 1);
    load_done = 1'b1;
    step(1); load_done = 1'b0;
    step(3);
    @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
